// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-unit definitions: FSM encoding, fault bit positions and the
// architectural NOP inserted on reset or on a faulted fetch.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] ARCH_NOP_INSN = 32'h0000_0013;

  localparam int FAULT_MISALIGNED = 0;
  localparam int FAULT_TIMEOUT    = 1;

  localparam int TIMEOUT_CNT_W = 8;

endpackage

// File: rtl/instruction_fetch_unit_timeout_counter.sv
// Loadable saturating up-counter with clear/enable; tc flags that the count
// equals TC_VALUE.
module fetch_timeout_counter #(
  parameter int unsigned       WIDTH    = 8,
  parameter logic [WIDTH-1:0]  TC_VALUE = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VALUE);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front-end: owns the PC, issues one ROM word read per accepted
// fetch-stage pulse and holds the returned word for the later stages.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned       XLEN           = 32,
  parameter logic [XLEN-1:0]   RESET_PC       = '0,
  parameter int unsigned       TIMEOUT_CYCLES = 15,
  parameter logic [XLEN-1:0]   NOP_INSN       = ARCH_NOP_INSN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_fetch_start,
  input  logic            i_pc_load,
  input  logic [XLEN-1:0] i_pc_next,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ready,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic [XLEN-1:0] o_instruction,
  output logic [XLEN-1:0] o_pc,
  output logic            o_valid,
  output logic            o_busy,
  output logic [1:0]      o_fault,
  output fetch_state_e    o_dbg_state
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] insn_q, insn_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [XLEN-1:0] fetch_pc;
  logic [1:0]      fault_q, fault_d;
  logic            valid_q, valid_d;
  logic            mem_req_q, mem_req_d;
  logic            pend_q, pend_d;
  logic            cnt_clr, cnt_en, cnt_tc, done;

  // WAIT cycle k sees count k-1, so tc on count TIMEOUT_CYCLES-1 bounds the
  // wait to exactly TIMEOUT_CYCLES cycles.
  fetch_timeout_counter #(
    .WIDTH    (TIMEOUT_CNT_W),
    .TC_VALUE (TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1))
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .load     (1'b0),
    .load_val ('0),
    .tc       (cnt_tc)
  );

  // Memory handshake: o_mem_req rises the cycle after an accepted start and
  // holds, with o_mem_addr stable, until i_mem_ready is sampled high or the
  // wait times out; a ready in the timeout cycle still delivers its data.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    insn_d    = insn_q;
    valid_d   = 1'b0;
    mem_req_d = mem_req_q;
    fault_d   = fault_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    done      = 1'b0;
    fetch_pc  = i_pc_load ? i_pc_next : pc_q;
    case (state_q)
      FETCH_IDLE: begin
        pc_d = fetch_pc;
        if (i_fetch_start) begin
          fault_d = '0;
          if (fetch_pc[1:0] != 2'b00) begin
            fault_d[FAULT_MISALIGNED] = 1'b1;
            insn_d                    = NOP_INSN;
            valid_d                   = 1'b1;
          end else begin
            state_d   = FETCH_REQ;
            mem_req_d = 1'b1;
          end
        end
      end
      FETCH_REQ: begin
        state_d = FETCH_WAIT;
        cnt_clr = 1'b1;
      end
      FETCH_WAIT: begin
        if (i_mem_ready) begin
          insn_d  = i_mem_rdata;
          valid_d = 1'b1;
          done    = 1'b1;
        end else if (cnt_tc) begin
          fault_d[FAULT_TIMEOUT] = 1'b1;
          insn_d                 = NOP_INSN;
          valid_d                = 1'b1;
          done                   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d   = FETCH_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
    // o_pc is frozen during a fetch; the last load seen while busy lands on
    // the return-to-idle edge.
    if ((state_q != FETCH_IDLE) && i_pc_load) begin
      pend_d    = 1'b1;
      pend_pc_d = i_pc_next;
    end
    if (done) begin
      state_d   = FETCH_IDLE;
      mem_req_d = 1'b0;
      pend_d    = 1'b0;
      if (i_pc_load) begin
        pc_d = i_pc_next;
      end else if (pend_q) begin
        pc_d = pend_pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH_IDLE;
      pc_q      <= RESET_PC;
      insn_q    <= NOP_INSN;
      valid_q   <= 1'b0;
      mem_req_q <= 1'b0;
      fault_q   <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      insn_q    <= insn_d;
      valid_q   <= valid_d;
      mem_req_q <= mem_req_d;
      fault_q   <= fault_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign o_mem_req     = mem_req_q;
  assign o_mem_addr    = pc_q;
  assign o_instruction = insn_q;
  assign o_pc          = pc_q;
  assign o_valid       = valid_q;
  assign o_busy        = (state_q != FETCH_IDLE);
  assign o_fault       = fault_q;
  assign o_dbg_state   = state_q;

endmodule
